// File: rtl/pipe_reg_file.sv
// pipe_reg_file: 2R/2W register file with issue scoreboard and a sequential clear engine.
// Optional macro PIPE_REG_FILE_BYPASS_EN enables same-cycle write-to-read forwarding.
`default_nettype none

module pipe_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic [DATA_WIDTH-1:0] r0_data,
  output logic [DATA_WIDTH-1:0] r1_data,
  output logic                  r0_pend,
  output logic                  r1_pend,
  input  logic                  w0_en,
  input  logic                  w1_en,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic                  iss_en,
  input  logic [ADDR_WIDTH-1:0] iss_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_pend;

  logic w_w0_ok;
  logic w_w1_ok;
  logic w_iss_ok;
  logic w_zero_en;

  assign w_zero_en = (ZERO_REG != 0);
  assign busy      = (r_state == ST_CLEAR);

  // Accepted operations: idle engine and not aimed at the hardwired zero entry.
  assign w_w0_ok  = w0_en  && !busy && !(w_zero_en && (w0_addr  == '0));
  assign w_w1_ok  = w1_en  && !busy && !(w_zero_en && (w1_addr  == '0));
  assign w_iss_ok = iss_en && !busy && !(w_zero_en && (iss_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_cnt == C_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Later assignments win: w1 over w0, and an issue set over a write clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend <= '0;
    end else if (busy) begin
      r_mem[r_cnt]  <= '0;
      r_pend[r_cnt] <= 1'b0;
    end else begin
      if (w_w0_ok) begin
        r_mem[w0_addr]  <= w0_data;
        r_pend[w0_addr] <= 1'b0;
      end
      if (w_w1_ok) begin
        r_mem[w1_addr]  <= w1_data;
        r_pend[w1_addr] <= 1'b0;
      end
      if (w_iss_ok) begin
        r_pend[iss_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    r0_data = r_mem[r0_addr];
    r0_pend = r_pend[r0_addr];
`ifdef PIPE_REG_FILE_BYPASS_EN
    if (w_w1_ok && (w1_addr == r0_addr)) begin
      r0_data = w1_data;
      r0_pend = w_iss_ok && (iss_addr == r0_addr);
    end else if (w_w0_ok && (w0_addr == r0_addr)) begin
      r0_data = w0_data;
      r0_pend = w_iss_ok && (iss_addr == r0_addr);
    end
`endif
    if (!rst_n || (w_zero_en && (r0_addr == '0))) begin
      r0_data = '0;
      r0_pend = 1'b0;
    end
  end

  always_comb begin
    r1_data = r_mem[r1_addr];
    r1_pend = r_pend[r1_addr];
`ifdef PIPE_REG_FILE_BYPASS_EN
    if (w_w1_ok && (w1_addr == r1_addr)) begin
      r1_data = w1_data;
      r1_pend = w_iss_ok && (iss_addr == r1_addr);
    end else if (w_w0_ok && (w0_addr == r1_addr)) begin
      r1_data = w0_data;
      r1_pend = w_iss_ok && (iss_addr == r1_addr);
    end
`endif
    if (!rst_n || (w_zero_en && (r1_addr == '0))) begin
      r1_data = '0;
      r1_pend = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/pipe_reg_file.md
PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of every register entry.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, giving DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clr_req  input  1  request a sequential clear of all entries.
REQ-007 busy  output  1  high while a clear is in progress.
REQ-008 r0_addr, r1_addr  input  ADDR_WIDTH  read-port addresses.
REQ-009 r0_data, r1_data  output  DATA_WIDTH  combinational read data.
REQ-010 r0_pend, r1_pend  output  1  scoreboard pending bit for the addressed entry.
REQ-011 w0_en, w1_en  input  1  write enables, port 0 and port 1.
REQ-012 w0_addr, w1_addr  input  ADDR_WIDTH  write addresses.
REQ-013 w0_data, w1_data  input  DATA_WIDTH  write data.
REQ-014 iss_en  input  1  marks iss_addr as pending (producer issued).
REQ-015 iss_addr  input  ADDR_WIDTH  destination being issued.

Function
REQ-016 Writes SHALL take effect at the rising edge when wN_en=1 and busy=0; stored data is visible on reads from the next cycle.
REQ-017 When w0 and w1 target the same address in one cycle, w1 data SHALL be stored.
REQ-018 With ZERO_REG=1, writes and issues to address 0 SHALL be ignored; reads of address 0 SHALL return 0 with pend=0.
REQ-019 Scoreboard: iss_en (busy=0) SHALL set pend[iss_addr]; any accepted write to an address SHALL clear its pend bit.
REQ-020 Issue and write to the same address in the same cycle: set SHALL win (pend=1 next cycle).
REQ-021 rN_pend SHALL equal pend[rN_addr] as registered, except as modified by REQ-031.
REQ-022 Clear FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1, counter loaded with 0.
REQ-023 In CLEAR, each cycle SHALL write zero to entry[counter] and clear pend[counter], then increment the counter; after entry DEPTH-1 the FSM SHALL return to IDLE (clear lasts exactly DEPTH cycles).
REQ-024 busy SHALL be 1 exactly while in CLEAR (registered, asserted the cycle after clr_req is sampled).
REQ-025 While busy=1, wN_en, iss_en and further clr_req SHALL be ignored; reads SHALL return current (partially cleared) contents.
REQ-026 Counter SHALL be ADDR_WIDTH bits and not wrap into a second pass.

Reset
REQ-027 On rst_n=0, asynchronously: all entries 0, all pend bits 0, FSM IDLE, counter 0, busy 0.
REQ-028 Reset asserted during CLEAR SHALL abort it immediately; after release the FSM is IDLE.
REQ-029 r0_data/r1_data SHALL read 0 and r0_pend/r1_pend 0 throughout reset.

Configuration
REQ-030 Macro PIPE_REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 Defined: if busy=0 and an enabled write targets rN_addr (not zero-register), rN_data SHALL return that write data same cycle (w1 over w0) and rN_pend SHALL be 0 unless iss_en targets the same address.
REQ-032 Not defined: reads SHALL return only stored contents; no same-cycle forwarding; rN_pend purely registered.

Verification
REQ-033 Write w0 addr3=0xDEADBEEF, read addr3 next cycle -> 0xDEADBEEF; same-cycle read -> bypass value if macro defined, else old value 0.
REQ-034 w0 addr5=0x11, w1 addr5=0x22 same cycle -> addr5 reads 0x22.
REQ-035 Write 0xFFFFFFFF to addr0 with ZERO_REG=1 -> addr0 reads 0, iss to addr0 leaves r0_pend=0.
REQ-036 iss addr2, then write addr2 two cycles later -> r0_pend(addr2) 1 for two cycles then 0; iss+write addr2 same cycle -> pend stays 1.
REQ-037 Fill all 8 entries nonzero, pulse clr_req -> busy high 8 cycles, writes during busy ignored, all entries 0 and pend 0 afterwards.
REQ-038 Assert rst_n=0 mid-clear (cycle 4) -> busy 0 and all entries 0 immediately, FSM IDLE after release.
